// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer arbiter: default image geometry,
// pixel/address widths, arbiter state encoding and the pipeline latency
// used to realign syncs with pixel data.
// No ports (package).
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int DEF_IMG_W      = 160;  // stored image width in pixels
  localparam int DEF_IMG_H      = 120;  // stored image height in pixels
  localparam int DEF_SCALE_LOG2 = 2;    // 4x upscale to 640x480
  localparam int DEF_PIX_W      = 12;   // 4:4:4 RGB
  localparam int DEF_ADDR_W     = 15;   // enough for 19200 locations

  localparam int FB_PIXELS = DEF_IMG_W * DEF_IMG_H;

  // Input sample -> registered BRAM request -> BRAM data -> registered rgb.
  localparam int FB_LATENCY = 3;

  typedef enum logic {
    BLANK = 1'b0,  // no complete image yet, screen forced black
    SHOW  = 1'b1   // image valid, display path live
  } fb_state_e;

endpackage : fb_pkg

// File: rtl/fb_delay.sv
// -----------------------------------------------------------------------------
// fb_delay
// N-stage, W-bit register pipe with an asynchronous reset value. Used to
// align sync and video_on/slot strobes with data coming back from the BRAM.
//
// Ports:
//   clk    in   1  clock
//   reset  in   1  asynchronous, active-high; every stage loads RST_VAL
//   d      in   W  pipe input
//   q      out  W  input delayed by N clock cycles
// -----------------------------------------------------------------------------
module fb_delay #(
  parameter int             N       = 1,
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [N];

  // NOTE: every stage is reset, not just the last one; a stale strobe left in
  // the middle of the pipe would otherwise emerge a few cycles after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) pipe[i] <= RST_VAL;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[N-1];

endmodule : fb_delay

// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
// Shares a single-port 160x120x12 frame-buffer BRAM between the VGA display
// path (one read every 2**SCALE_LOG2 active pixels) and the SD-card loader
// (writes in every other cycle). Realigns hsync/vsync with the pixel data
// (fixed latency 3) and blanks the screen until a full image is loaded.
//
// Optional feature: define FB_STALL_CNT_EN to add the stall_cnt output, a
// saturating count of loader cycles spent waiting (wr_valid && !wr_ready),
// cleared by reset and by an accepted wr_sof beat.
//
// Ports:
//   clk           in   1       pixel clock, 25 MHz
//   reset         in   1       asynchronous, active-high
//   hsync_in      in   1       active-low hsync from timing generator
//   vsync_in      in   1       active-low vsync from timing generator
//   video_on      in   1       active display area
//   x, y          in   10      current pixel coordinate
//   wr_valid      in   1       loader pixel valid
//   wr_sof        in   1       loader start-of-frame, qualifies current beat
//   wr_data       in   PIX_W   loader pixel
//   wr_ready      out  1       beat accepted when wr_valid && wr_ready
//   mem_en        out  1       BRAM enable
//   mem_we        out  1       BRAM write enable
//   mem_addr      out  ADDR_W  BRAM address
//   mem_wdata     out  PIX_W   BRAM write data
//   mem_rdata     in   PIX_W   BRAM read data (1-cycle synchronous read)
//   rgb           out  PIX_W   pixel to DAC
//   hsync, vsync  out  1       delayed syncs, active-low
//   frame_loaded  out  1       pulse with the write of the last image pixel
//   stall_cnt     out  16      loader stall cycles (FB_STALL_CNT_EN only)
//   displaying    out  1       high in state SHOW
// -----------------------------------------------------------------------------
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              video_on,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              wr_valid,
  input  logic              wr_sof,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_loaded,
`ifdef FB_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              displaying
);

  localparam int                PIXELS    = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  // ---------------------------------------------------------------------------
  // Slot arbitration: the display owns the first pixel of every upscaled
  // group; every other cycle (including all blanking) belongs to the loader.
  // ---------------------------------------------------------------------------
  logic              slot;
  logic              accept;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] wa;

  assign slot     = video_on && (x[SCALE_LOG2-1:0] == '0);
  assign wr_ready = !slot;
  assign accept   = wr_valid && wr_ready;

  // IMG_W is an elaboration constant, so this reduces to shifts and adds.
  assign rd_addr = ADDR_W'(y >> SCALE_LOG2) * ADDR_W'(IMG_W)
                 + ADDR_W'(x >> SCALE_LOG2);

  // A start-of-frame beat restarts the image regardless of where wa is.
  assign wr_addr = wr_sof ? '0 : wa;

  // ---------------------------------------------------------------------------
  // Registered BRAM request and write address counter
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only, so every
  // register here sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wa           <= '0;
      frame_loaded <= 1'b0;
    end else begin
      mem_en       <= slot || accept;
      mem_we       <= accept;
      frame_loaded <= 1'b0;
      if (slot) begin
        mem_addr <= rd_addr;
      end else if (accept) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
        if (wr_addr == LAST_ADDR) begin
          wa           <= '0;
          frame_loaded <= 1'b1;
        end else begin
          wa <= wr_addr + ADDR_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display FSM: BLANK until the first complete image, then SHOW for good.
  // ---------------------------------------------------------------------------
  fb_state_e state_q;
  fb_state_e state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BLANK;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (frame_loaded) state_d = SHOW;
      SHOW:    state_d = SHOW;
      default: state_d = BLANK;
    endcase
  end

  assign displaying = (state_q == SHOW);

  // ---------------------------------------------------------------------------
  // Alignment pipes. video_on/slot need two stages: they are consumed at the
  // edge where the BRAM data arrives, which is also the edge that registers
  // rgb. Syncs need all three stages to emerge together with rgb.
  // ---------------------------------------------------------------------------
  logic [1:0] strobe_d2;
  logic       video_on_d2;
  logic       slot_d2;
  logic [1:0] sync_d3;

  fb_delay #(
    .N       (FB_LATENCY - 1),
    .W       (2),
    .RST_VAL (2'b00)
  ) u_strobe_dly (
    .clk   (clk),
    .reset (reset),
    .d     ({video_on, slot}),
    .q     (strobe_d2)
  );

  fb_delay #(
    .N       (FB_LATENCY),
    .W       (2),
    .RST_VAL (2'b11)
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .d     ({hsync_in, vsync_in}),
    .q     (sync_d3)
  );

  assign {video_on_d2, slot_d2} = strobe_d2;
  assign {hsync, vsync}         = sync_d3;

  // ---------------------------------------------------------------------------
  // Pixel hold and output. The freshly read word bypasses the hold register
  // so the first pixel of each group is not one group late.
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] pix;
  logic [PIX_W-1:0] pix_d;

  always_comb begin
    pix_d = pix;
    if (slot_d2) pix_d = mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix <= '0;
      rgb <= '0;
    end else begin
      pix <= pix_d;
      rgb <= (video_on_d2 && (state_q == SHOW)) ? pix_d : '0;
    end
  end

`ifdef FB_STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Loader stall counter, saturating.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (accept && wr_sof) begin
      stall_cnt <= '0;
    end else if (wr_valid && !wr_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule : fb_arbiter

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
// Directed testbench for fb_arbiter with a behavioural single-port BRAM
// (read-first, 1-cycle read latency). Expected values are computed from the
// stimulus: pixel data follows pix_val(), addresses from the image geometry.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync_in, vsync_in, video_on;
  logic [9:0]  x, y;
  logic        wr_valid, wr_sof;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = '0;
  logic [11:0] rgb;
  logic        hsync, vsync;
  logic        frame_loaded;
  logic        displaying;
`ifdef FB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .video_on     (video_on),
    .x            (x),
    .y            (y),
    .wr_valid     (wr_valid),
    .wr_sof       (wr_sof),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .rgb          (rgb),
    .hsync        (hsync),
    .vsync        (vsync),
    .frame_loaded (frame_loaded),
`ifdef FB_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .displaying   (displaying)
  );

  always #20 clk = ~clk;

  // Frame-buffer BRAM, prefilled with a non-zero pattern so blanking is visible.
  logic [11:0] mem [FB_PIXELS] = '{default: 12'h555};

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  function automatic logic [11:0] pix_val(input int i);
    return (i == 1) ? 12'hABC : 12'(i * 37 + 5);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Eight active pixels starting at x0 on line yy, then three blanking cycles.
  task automatic show_row(input int yy, input int x0);
    for (int c = 0; c < 11; c++) begin
      video_on = (c < 8);
      x        = 10'(x0 + c);
      y        = 10'(yy);
      tick();
      if (c < 8 && (c % 4) == 0) begin
        check("row_rd_en",   32'(mem_en), 32'd1);
        check("row_rd_we",   32'(mem_we), 32'd0);
        check("row_rd_addr", 32'(mem_addr), 32'((yy / 4) * DEF_IMG_W + (x0 + c) / 4));
      end else begin
        check("row_idle_en", 32'(mem_en), 32'd0);
      end
      if (c >= 2 && c < 10)
        check("row_rgb", 32'(rgb), 32'(pix_val((yy / 4) * DEF_IMG_W + (x0 + c - 2) / 4)));
      else
        check("row_rgb_off", 32'(rgb), 32'd0);
    end
  endtask

  initial begin
    int fl_cnt;
    int exp_wa;

    // ---- reset state ----
    reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; video_on = 1'b0;
    x = '0; y = '0; wr_valid = 1'b0; wr_sof = 1'b0; wr_data = '0;
    tick(); tick();
    check("rst_rgb",       32'(rgb), 32'd0);
    check("rst_hsync",     32'(hsync), 32'd1);
    check("rst_vsync",     32'(vsync), 32'd1);
    check("rst_mem_en",    32'(mem_en), 32'd0);
    check("rst_mem_we",    32'(mem_we), 32'd0);
    check("rst_mem_addr",  32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_frame_ld",  32'(frame_loaded), 32'd0);
    check("rst_display",   32'(displaying), 32'd0);
    video_on = 1'b1; x = 10'd0; #1;
    check("rst_wr_ready_slot", 32'(wr_ready), 32'd0);
    x = 10'd1; #1;
    check("rst_wr_ready_free", 32'(wr_ready), 32'd1);
    video_on = 1'b0; x = '0;
    reset = 1'b0;

    // ---- BLANK: no loader, rgb stays 0, syncs shifted by the pipe ----
    for (int c = 0; c < 64; c++) begin
      video_on = ((c % 16) < 12);
      x        = 10'(c % 16);
      y        = 10'(c / 16);
      hsync_in = ((c % 10) >= 2);
      vsync_in = ((c % 23) >= 3);
      tick();
      check("blank_rgb",     32'(rgb), 32'd0);
      check("blank_display", 32'(displaying), 32'd0);
      if (c >= 2) begin
        check("blank_hsync", 32'(hsync), 32'(((c - 2) % 10) >= 2));
        check("blank_vsync", 32'(vsync), 32'(((c - 2) % 23) >= 3));
      end else begin
        check("blank_hsync_rst", 32'(hsync), 32'd1);
      end
    end

    // ---- full image load during blanking ----
    video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; x = '0; y = '0;
    fl_cnt = 0;
    for (int i = 0; i < FB_PIXELS; i++) begin
      wr_valid = 1'b1;
      wr_sof   = (i == 0);
      wr_data  = pix_val(i);
      tick();
      check("load_addr", 32'(mem_addr), 32'(i));
      check("load_we",   32'(mem_we), 32'd1);
      if (frame_loaded) fl_cnt++;
      if (i == 1) check("load_wdata_abc", 32'(mem_wdata), 32'h0ABC);
    end
    check("load_fl_last",     32'(frame_loaded), 32'd1);
    check("load_disp_before", 32'(displaying), 32'd0);
    check("load_fl_count",    32'(fl_cnt), 32'd1);
    wr_valid = 1'b0; wr_sof = 1'b0;
    tick();
    check("load_fl_gone",    32'(frame_loaded), 32'd0);
    check("load_disp_after", 32'(displaying), 32'd1);
    check("load_idle_en",    32'(mem_en), 32'd0);

    // ---- display: 4x upscale, first and last image pixels ----
    show_row(0, 0);
    show_row(1, 0);
    show_row(2, 0);
    show_row(3, 0);
    show_row(4, 0);
    show_row(476, 632);

    // ---- loader streaming during an active line ----
    exp_wa = 0;
    for (int c = 0; c < 16; c++) begin
      video_on = 1'b1; x = 10'(c); y = 10'd8;
      wr_valid = 1'b1; wr_sof = 1'b0; wr_data = pix_val(exp_wa);
      #1;
      check("bw_wr_ready", 32'(wr_ready), 32'((c % 4) != 0));
      tick();
      check("bw_en", 32'(mem_en), 32'd1);
      if ((c % 4) == 0) begin
        check("bw_rd_we",   32'(mem_we), 32'd0);
        check("bw_rd_addr", 32'(mem_addr), 32'(2 * DEF_IMG_W + c / 4));
      end else begin
        check("bw_wr_we",   32'(mem_we), 32'd1);
        check("bw_wr_addr", 32'(mem_addr), 32'(exp_wa));
        exp_wa++;
      end
    end

    // ---- advance to wa=5000, then a mid-frame start-of-frame ----
    video_on = 1'b0;
    fl_cnt   = 0;
    while (exp_wa < 5000) begin
      wr_data = pix_val(exp_wa);
      tick();
      check("adv_addr", 32'(mem_addr), 32'(exp_wa));
      if (frame_loaded) fl_cnt++;
      exp_wa++;
    end
    wr_sof = 1'b1; wr_data = pix_val(0);
    tick();
    check("sof_addr", 32'(mem_addr), 32'd0);
    check("sof_we",   32'(mem_we), 32'd1);
    if (frame_loaded) fl_cnt++;
    wr_sof = 1'b0; wr_data = pix_val(1);
    tick();
    check("sof_next_addr", 32'(mem_addr), 32'd1);
    if (frame_loaded) fl_cnt++;
    wr_valid = 1'b0;
    tick();
    if (frame_loaded) fl_cnt++;
    check("sof_no_frame_ld", 32'(fl_cnt), 32'd0);
    check("sof_still_show",  32'(displaying), 32'd1);

    // ---- reset in the middle of line 200 while showing ----
    y = 10'd200; video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      x = 10'(c);
      tick();
    end
    check("pre_rst_rgb",   32'(rgb), 32'(pix_val(50 * DEF_IMG_W)));
    check("pre_rst_hsync", 32'(hsync), 32'd0);
    check("pre_rst_vsync", 32'(vsync), 32'd0);
    reset = 1'b1;
    #1;
    check("async_rst_rgb",   32'(rgb), 32'd0);
    check("async_rst_hsync", 32'(hsync), 32'd1);
    check("async_rst_vsync", 32'(vsync), 32'd1);
    check("async_rst_disp",  32'(displaying), 32'd0);
    check("async_rst_en",    32'(mem_en), 32'd0);
    tick();
    check("rst_hold_rgb",  32'(rgb), 32'd0);
    check("rst_hold_disp", 32'(displaying), 32'd0);
    reset = 1'b0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 12'h123;
    tick();
    check("post_rst_wa",    32'(mem_addr), 32'd0);
    check("post_rst_we",    32'(mem_we), 32'd1);
    check("post_rst_wdata", 32'(mem_wdata), 32'h123);
    wr_valid = 1'b0;
    tick(); tick();
    check("post_rst_rgb",  32'(rgb), 32'd0);
    check("post_rst_disp", 32'(displaying), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fb_arbiter

// File: doc/fb_arbiter.md
# fb_arbiter

Shares the single-port 160x120x12-bit frame-buffer BRAM between the VGA display path and the SD-card image loader. Sits between the 640x480@60 Hz sync generator (25 MHz pixel clock) and the BRAM. It issues one display read every fourth active pixel (4x upscale to 640x480) and grants loader writes in every other cycle. It realigns sync with pixel data and blanks the screen until a full image has been loaded.

## Interface

Parameters:
- IMG_W, 160, stored image width in pixels
- IMG_H, 120, stored image height in pixels
- SCALE_LOG2, 2, upscale factor as log2 (4x)
- PIX_W, 12, pixel width (4:4:4 RGB)
- ADDR_W, 15, BRAM address width (≥ log2(IMG_W*IMG_H))

Ports:
- clk  in  1  pixel clock, 25 MHz
- reset  in  1  asynchronous, active-high
- hsync_in, vsync_in  in  1  active-low syncs from timing generator
- video_on  in  1  active display area
- x, y  in  10  current pixel coordinate
- wr_valid  in  1  loader pixel valid
- wr_sof  in  1  loader start-of-frame; qualifies the current beat
- wr_data  in  PIX_W  loader pixel
- wr_ready  out  1  beat accepted when wr_valid && wr_ready
- mem_en, mem_we  out  1  BRAM enable / write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  PIX_W  BRAM write data
- mem_rdata  in  PIX_W  BRAM read data, 1-cycle synchronous read
- rgb  out  PIX_W  pixel to DAC
- hsync, vsync  out  1  delayed syncs, active-low
- frame_loaded  out  1  one-cycle pulse on the last pixel of each loaded frame
- displaying  out  1  high in state SHOW

## Operation

- Display slot at cycle t: video_on && x[SCALE_LOG2-1:0]==0.
  - Read address = (y>>SCALE_LOG2)*IMG_W + (x>>SCALE_LOG2).
  - Multiply by constant IMG_W only, no general multiplier.
- wr_ready = !display_slot (combinational). Any non-slot cycle is a write slot, including all blanking. Active-region write bandwidth is 3/4.
- Write address counter wa:
  - An accepted beat writes to wa, or to 0 if wr_sof is set.
  - Next wa = written address + 1.
  - A write to IMG_W*IMG_H-1 wraps wa to 0 and pulses frame_loaded on the next cycle.
- wr_valid without wr_ready: beat held by the loader; wa unchanged.
- Pixel hold register pix: loaded from mem_rdata two cycles after a display slot. It is held for the remaining SCALE-1 pixels.
- FSM:
  - BLANK (after reset): rgb forced 0.
  - BLANK→SHOW on the first frame_loaded.
  - SHOW is terminal until reset. A reload while in SHOW updates the image live; tearing is accepted.
- rgb = (video_on delayed 3 && state==SHOW) ? pix : 0.
- Reset mid-frame:
  - All registers clear immediately.
  - wa=0, state BLANK.
  - Any in-flight read is discarded.

## Timing

- Inputs sampled at edge t. mem_en/mem_we/mem_addr/mem_wdata are registered and valid in cycle t+1.
- mem_rdata valid t+2; rgb/hsync/vsync registered, valid t+3. Fixed latency 3 for data and syncs.
- Reset values:
  - rgb=0
  - hsync=vsync=1
  - mem_en=mem_we=0, mem_addr=0, mem_wdata=0
  - frame_loaded=0, displaying=0
  - wr_ready follows the combinational rule.
- Idle cycle (no slot, no beat): mem_en=0.
- Simultaneous display slot and wr_valid: the read wins and wr_ready=0.

## Configuration

- FB_STALL_CNT_EN defined:
  - Adds output stall_cnt[15:0], counting cycles with wr_valid && !wr_ready.
  - Saturates at 0xFFFF; cleared by reset and by an accepted wr_sof beat.
- FB_STALL_CNT_EN undefined: port and counter absent; behaviour otherwise identical.

## Structure

- Shared package fb_pkg:
  - IMG_W, IMG_H, SCALE_LOG2, PIX_W, ADDR_W defaults.
  - State encoding BLANK=1'b0, SHOW=1'b1.
  - Constant FB_PIXELS=IMG_W*IMG_H.
- Sub-module fb_delay: parameterized N-stage, W-bit register pipe with async reset value. Used for the sync/video_on/slot delays.

## Test plan

- Reset, no loader activity, 2 frames -> rgb=0 throughout; displaying=0; hsync/vsync identical to inputs shifted by 3 cycles.
- Stream 19200 beats with wr_valid=1 from wr_sof -> first write mem_addr=0, last 19199; frame_loaded pulses once; displaying=1 next cycle.
- Load pixel (row 0, col 1)=0xABC, then display x=4..7, y=0..3 -> rgb=0xABC for those 16 pixels at +3 cycles; mem_addr=1 issued only at x=4.
- wr_valid held high during active line -> wr_ready low exactly when x%4==0. Accepted beats = 3 per 4 active cycles, no lost or duplicated addresses.
- wr_sof asserted mid-frame at wa=5000 -> that beat writes address 0; no frame_loaded pulse.
- Assert reset at y=200 during SHOW -> next cycle rgb=0, hsync=vsync=1, displaying=0, wa restarts at 0.
